// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI request arbiter.
package spi_arb_pkg;

  localparam int SPI_DATA_W  = 16;
  localparam int SPI_TMO_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after index `last`.
module rr_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  // Walk from the lowest priority (last itself) up to last+1, so the
  // highest-priority hit is the final assignment and wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so
    // no path through the block leaves a value held (no latch).
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin scheduler sharing one SPI master engine between NUM_REQ
// requesters; one word in, one word (or timeout error) back per transaction.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TIMEOUT_CYC = SPI_TMO_DEF
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_wdata,
  output logic [NUM_REQ-1:0]        eng_ss_sel,
  input  logic                      eng_busy,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   grant, last, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt, grant_oh;
  logic [DATA_W-1:0]  wdata, rdata;
  logic               err;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               accept, tmo_hit;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req     (req_valid),
    .last    (last),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  assign accept   = |req_ready;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;

  always_ff @(posedge PCLK or posedge PRESET) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (eng_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; the counter stops rather than wraps when it expires.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      grant   <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
      wdata   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant <= pick_idx;
            wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
          end
        end
        START: tmo_cnt <= '0;
        WAIT: begin
          if (eng_done) begin
            rdata <= eng_rdata;
            err   <= 1'b0;
          end else if (tmo_hit) begin
            rdata <= '0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP:    last <= grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    eng_ss_sel = '0;
    eng_start  = 1'b0;
    unique case (state)
      IDLE:    if (!eng_busy) req_ready = pick_gnt;
      START: begin
        eng_start  = 1'b1;
        eng_ss_sel = grant_oh;
      end
      WAIT:    eng_ss_sel = grant_oh;
      RESP:    rsp_valid  = grant_oh;
      default: ;
    endcase
  end

  assign eng_wdata = wdata;
  assign rsp_rdata = rdata;
  assign rsp_err   = err;

endmodule
